// File: rtl/if_pkg.sv
// Shared types and instruction field layout for the fetch stage and any later
// pipeline stage that decodes the same ARM-subset word.
package if_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        FLUSH,
        FAULT
    } fetch_state_t;

    localparam int COND_HI  = 31;
    localparam int COND_LO  = 28;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 26;
    localparam int FUNCT_HI = 25;
    localparam int FUNCT_LO = 20;
    localparam int RN_HI    = 19;
    localparam int RN_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fields.sv
// Combinational field slicer for the upper instruction bits (Cond..Rd).
// The port keeps absolute bit numbering so the package positions apply directly.
module instr_fields
    import if_pkg::*;
(
    input  logic [COND_HI:RD_LO] instr_hi,
    output logic [3:0]           cond,
    output logic [1:0]           op_code,
    output logic [5:0]           funct,
    output logic [3:0]           rn,
    output logic [3:0]           rd
);

    assign cond    = instr_hi[COND_HI:COND_LO];
    assign op_code = instr_hi[OP_HI:OP_LO];
    assign funct   = instr_hi[FUNCT_HI:FUNCT_LO];
    assign rn      = instr_hi[RN_HI:RN_LO];
    assign rd      = instr_hi[RD_HI:RD_LO];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack fetch, registered word and decode fields.
// Optional bus-error fault state is built when IF_BUSERR_EN is defined.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
`ifdef IF_BUSERR_EN
    input  logic        imem_err,
    output logic        fetch_fault,
`endif
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus8,
    output logic [3:0]  Cond,
    output logic [1:0]  OpCode,
    output logic [5:0]  Funct,
    output logic [3:0]  Rd,
    output logic [3:0]  Rn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  addr_reg;
    logic [31:0]  instr_reg;
    logic         req_reg;
    logic         valid_reg;
    logic [31:0]  redirect_pc;
    logic [31:0]  pc_seq_next;
`ifdef IF_BUSERR_EN
    logic         fault_reg;
`endif

    assign redirect_pc = redirect_target & ~32'h3;
    assign pc_seq_next = pc_reg + PC_STEP;

    // addr_reg is separate from pc_reg: a FLUSH keeps the stale address on the
    // bus while pc_reg already holds the redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            addr_reg  <= RESET_PC;
            instr_reg <= 32'h0;
            req_reg   <= 1'b0;
            valid_reg <= 1'b0;
`ifdef IF_BUSERR_EN
            fault_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg <= FETCH;
                    req_reg   <= 1'b1;
                    addr_reg  <= pc_reg;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        pc_reg    <= redirect_pc;
                        valid_reg <= 1'b0;
                        if (imem_ack) begin
                            addr_reg <= redirect_pc;
                        end else begin
                            state_reg <= FLUSH;
                        end
                    end else if (imem_ack) begin
`ifdef IF_BUSERR_EN
                        if (imem_err) begin
                            state_reg <= FAULT;
                            req_reg   <= 1'b0;
                            valid_reg <= 1'b0;
                            fault_reg <= 1'b1;
                        end else
`endif
                        begin
                            instr_reg <= imem_rdata;
                            state_reg <= ISSUE;
                            req_reg   <= 1'b0;
                            valid_reg <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Redirect has priority over a simultaneous accept.
                    if (redirect_valid) begin
                        pc_reg    <= redirect_pc;
                        addr_reg  <= redirect_pc;
                        valid_reg <= 1'b0;
                        req_reg   <= 1'b1;
                        state_reg <= FETCH;
                    end else if (instr_ready) begin
                        pc_reg    <= pc_seq_next;
                        addr_reg  <= pc_seq_next;
                        valid_reg <= 1'b0;
                        req_reg   <= 1'b1;
                        state_reg <= FETCH;
                    end
                end
                FLUSH: begin
                    if (redirect_valid) begin
                        pc_reg <= redirect_pc;
                    end
                    if (imem_ack) begin
                        addr_reg  <= redirect_valid ? redirect_pc : pc_reg;
                        state_reg <= FETCH;
                    end
                end
`ifdef IF_BUSERR_EN
                FAULT: begin
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                end
`endif
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_reg;
    assign imem_addr   = addr_reg;
    assign instr_valid = valid_reg;
    assign instr       = instr_reg;
    assign pc_out      = pc_reg;
    assign pc_plus8    = pc_reg + 32'd8;
`ifdef IF_BUSERR_EN
    assign fetch_fault = fault_reg;
`endif

    instr_fields u_fields (
        .instr_hi (instr_reg[COND_HI:RD_LO]),
        .cond     (Cond),
        .op_code  (OpCode),
        .funct    (Funct),
        .rn       (Rn),
        .rd       (Rd)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table-driven fetch/issue transactions
// with a scoreboard, plus hand sequences for redirects, wrap and (IF_BUSERR_EN) faults.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus8;
    logic [3:0]  Cond;
    logic [1:0]  OpCode;
    logic [5:0]  Funct;
    logic [3:0]  Rd;
    logic [3:0]  Rn;
    logic        redirect_valid;
    logic [31:0] redirect_target;
`ifdef IF_BUSERR_EN
    logic        imem_err;
    logic        fetch_fault;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
`ifdef IF_BUSERR_EN
        .imem_err        (imem_err),
        .fetch_fault     (fetch_fault),
`endif
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .pc_out          (pc_out),
        .pc_plus8        (pc_plus8),
        .Cond            (Cond),
        .OpCode          (OpCode),
        .Funct           (Funct),
        .Rd              (Rd),
        .Rn              (Rn),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    typedef struct {
        logic [31:0] data;
        int          ack_dly;
        int          rdy_dly;
        bit          redir;
        logic [31:0] tgt;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
    } exp_t;

    vec_t        tbl[5];
    exp_t        sb[$];
    logic [31:0] exp_pc;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
        else $display("ok   %s = %h", name, act);
    endtask

    task automatic cmp_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " scoreboard_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb[0];
            check({tag, " instr_valid"}, 32'(instr_valid), 32'd1);
            check({tag, " instr"},       instr,            e.data);
            check({tag, " pc_out"},      pc_out,           e.addr);
            check({tag, " pc_plus8"},    pc_plus8,         e.addr + 32'd8);
            check({tag, " Cond"},        32'(Cond),        32'(e.cond));
            check({tag, " OpCode"},      32'(OpCode),      32'(e.op));
            check({tag, " Funct"},       32'(Funct),       32'(e.funct));
            check({tag, " Rn"},          32'(Rn),          32'(e.rn));
            check({tag, " Rd"},          32'(Rd),          32'(e.rd));
        end
    endtask

    // One fetch + issue transaction driven from a table record.
    task automatic do_txn(input string tag, input vec_t v);
        exp_t        e;
        logic [31:0] held_addr;
        for (int i = 0; i < 20 && !imem_req; i++) step();
        check({tag, " req_seen"}, 32'(imem_req), 32'd1);
        check({tag, " imem_addr"}, imem_addr, exp_pc);
        held_addr = imem_addr;
        for (int d = 0; d < v.ack_dly; d++) begin
            step();
            check({tag, " addr_stable"}, imem_addr, held_addr);
            check({tag, " no_valid_in_fetch"}, 32'(instr_valid), 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = v.data;
        e = '{addr: exp_pc, data: v.data, cond: v.cond, op: v.op,
              funct: v.funct, rn: v.rn, rd: v.rd};
        sb.push_back(e);
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        for (int r = 0; r < v.rdy_dly; r++) begin
            cmp_front({tag, " hold"});
            check({tag, " req_low_in_issue"}, 32'(imem_req), 32'd0);
            step();
        end
        instr_ready = 1'b1;
        if (v.redir) begin
            redirect_valid  = 1'b1;
            redirect_target = v.tgt;
        end
        cmp_front({tag, " accept"});
        if (sb.size() != 0) void'(sb.pop_front());
        step();
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        exp_pc = v.redir ? (v.tgt & ~32'h3) : exp_pc + 32'd4;
        check({tag, " valid_drops"}, 32'(instr_valid), 32'd0);
        check({tag, " next_req"}, 32'(imem_req), 32'd1);
        check({tag, " next_addr"}, imem_addr, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_addr;
        vec_t        v;

        tbl[0] = '{data: 32'hE281_1001, ack_dly: 0, rdy_dly: 0, redir: 1'b0, tgt: 32'h0,
                   cond: 4'hE, op: 2'b00, funct: 6'b101000, rn: 4'h1, rd: 4'h1};
        tbl[1] = '{data: 32'hE591_2004, ack_dly: 3, rdy_dly: 4, redir: 1'b0, tgt: 32'h0,
                   cond: 4'hE, op: 2'b01, funct: 6'b011001, rn: 4'h1, rd: 4'h2};
        tbl[2] = '{data: 32'h0A00_0003, ack_dly: 1, rdy_dly: 2, redir: 1'b1, tgt: 32'h200,
                   cond: 4'h0, op: 2'b10, funct: 6'b100000, rn: 4'h0, rd: 4'h0};
        tbl[3] = '{data: 32'h1C4F_3ABC, ack_dly: 0, rdy_dly: 1, redir: 1'b1, tgt: 32'hFFFF_FFFC,
                   cond: 4'h1, op: 2'b11, funct: 6'b000100, rn: 4'hF, rd: 4'h3};
        tbl[4] = '{data: 32'hDEAD_BEEF, ack_dly: 2, rdy_dly: 0, redir: 1'b0, tgt: 32'h0,
                   cond: 4'hD, op: 2'b11, funct: 6'b101010, rn: 4'hD, rd: 4'hB};

        rst_n           = 1'b0;
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
`ifdef IF_BUSERR_EN
        imem_err        = 1'b0;
`endif
        step();
        step();
        check("rst imem_req",    32'(imem_req),    32'd0);
        check("rst instr_valid", 32'(instr_valid), 32'd0);
        check("rst instr",       instr,            32'h0);
        check("rst pc_out",      pc_out,           32'h0);
        check("rst fields",      {16'h0, Cond, OpCode, Funct, Rn}, 32'h0);
        check("rst Rd",          32'(Rd),          32'd0);
        rst_n = 1'b1;
        step();
        check("cycle1 imem_req",  32'(imem_req), 32'd1);
        check("cycle1 imem_addr", imem_addr,     32'h0);
        exp_pc = 32'h0;

        // Table: plain fetches, slow ack/ready, redirect+ready, wrap at the top of memory.
        for (int i = 0; i < 5; i++) begin
            do_txn($sformatf("vec%0d", i), tbl[i]);
        end
        check("wrap next_addr", imem_addr, 32'h0000_0000);

        // Redirect in FETCH without ack: stale request completes and is discarded.
        old_addr        = imem_addr;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        step();
        redirect_valid  = 1'b0;
        check("flush req_held",   32'(imem_req),    32'd1);
        check("flush stale_addr", imem_addr,        old_addr);
        check("flush no_valid",   32'(instr_valid), 32'd0);
        step();
        check("flush no_valid2",  32'(instr_valid), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBADB_AD00;
        step();
        imem_ack   = 1'b0;
        check("flush no_valid3",  32'(instr_valid), 32'd0);
        check("flush new_addr",   imem_addr,        32'h100);
        exp_pc = 32'h100;
        do_txn("after_flush", tbl[0]);

        // Redirect with a same-cycle ack in FETCH: data dropped, low bits forced to zero.
        imem_ack        = 1'b1;
        imem_rdata      = 32'h5555_AAAA;
        redirect_valid  = 1'b1;
        redirect_target = 32'h301;
        step();
        imem_ack        = 1'b0;
        redirect_valid  = 1'b0;
        check("redir_ack no_valid", 32'(instr_valid), 32'd0);
        check("redir_ack req",      32'(imem_req),    32'd1);
        check("redir_ack addr",     imem_addr,        32'h300);
        exp_pc = 32'h300;
        do_txn("after_redir_ack", tbl[1]);

`ifdef IF_BUSERR_EN
        v       = tbl[0];
        v.redir = 1'b1;
        v.tgt   = 32'h8;
        do_txn("to_err", v);
        imem_ack = 1'b1;
        imem_err = 1'b1;
        step();
        imem_ack = 1'b0;
        imem_err = 1'b0;
        check("err fetch_fault", 32'(fetch_fault), 32'd1);
        check("err req_low",     32'(imem_req),    32'd0);
        check("err no_valid",    32'(instr_valid), 32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        step();
        redirect_valid  = 1'b0;
        step();
        check("err sticky",      32'(fetch_fault), 32'd1);
        check("err redir_ign",   32'(imem_req),    32'd0);
        rst_n = 1'b0;
        #1;
        check("err rst_clears",  32'(fetch_fault), 32'd0);
        check("err rst_pc",      pc_out,           32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("err restart_req",  32'(imem_req), 32'd1);
        check("err restart_addr", imem_addr,     32'h0);
`else
        v = tbl[0];
        check("final req", 32'(imem_req), 32'(v.ack_dly == 0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer end of the decoder interface.
- Fetches 32-bit ARM-subset instructions from instruction memory over a req/ack handshake, holds the PC, and registers the fetched word.
- Splits the word into the fields the decoder consumes (Cond, OpCode, Funct, Rd, Rn), with a valid/ready handshake toward decode.
- Takes a redirect (PCS-taken plus target) back from execute and flushes any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment for a sequential fetch.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch address, stable while imem_req=1
imem_ack  in  1  memory returns data this cycle; same-cycle ack allowed
imem_rdata  in  32  instruction word, valid when imem_ack=1
instr_valid  out  1  instr and fields valid for decode
instr_ready  in  1  decode consumes instr this cycle
instr  out  32  registered instruction word
pc_out  out  32  address of instr
pc_plus8  out  32  pc_out+8 (ARM R15 read value)
Cond  out  4  instr[31:28]
OpCode  out  2  instr[27:26]
Funct  out  6  instr[25:20]
Rd  out  4  instr[15:12]
Rn  out  4  instr[19:16]
redirect_valid  in  1  branch/PC-write taken, from PCS path
redirect_target  in  32  new PC, word-aligned

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE.
  - pc = RESET_PC.
  - instr = 0.
  - imem_req = 0, instr_valid = 0.
  - All field outputs = 0.
- Registered outputs: imem_req, imem_addr and instr_valid come from registers. imem_addr = pc.
- States:
  - IDLE → FETCH unconditionally on the first clock after reset release.
  - FETCH: imem_req=1.
    - On imem_ack: instr ← imem_rdata, go to ISSUE.
    - Without ack: stay; imem_addr does not change.
  - ISSUE: instr_valid=1, imem_req=0.
    - On instr_ready: pc ← pc+PC_STEP (32-bit wrap, 0xFFFF_FFFC → 0x0), go to FETCH.
    - Otherwise hold instr and all fields stable.
  - FLUSH: imem_req=1 with the stale address until imem_ack. The returned data is discarded. Then go to FETCH with the new pc.
- Redirect, accepted in any state except IDLE:
  - pc ← redirect_target (bits [1:0] forced to 0) and instr_valid drops the next cycle.
  - In FETCH without ack that cycle: go to FLUSH (an outstanding request cannot be cancelled).
  - In FETCH with ack that same cycle: data discarded, go to FETCH.
  - In ISSUE: go to FETCH. Redirect wins over a simultaneous instr_ready; no +4 is applied.
  - In FLUSH: update pc only, stay in FLUSH until the ack arrives.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ack, then ISSUE with ready).
- Latency from imem_ack to instr_valid: 1 cycle.
- Field outputs are combinational slices of the registered instr. They are valid only while instr_valid=1.
- Reset mid-transaction drops imem_req immediately. The memory must tolerate an abandoned request.

Optional Feature:
IF_BUSERR_EN:
- Defined:
  - Adds input imem_err (qualified by imem_ack) and output fetch_fault (reset 0).
  - An ack with err in FETCH goes to state FAULT: fetch_fault=1, imem_req=0, instr_valid=0.
  - FAULT is sticky until reset; redirects are ignored there.
  - An error on a FLUSH ack is ignored, because that data is discarded.
- Undefined: neither port exists and the FAULT state is not built.

Decomposition:
- Package if_pkg:
  - fetch_state_t enum {IDLE, FETCH, ISSUE, FLUSH, FAULT}.
  - Field bit-position localparams (COND_HI/LO, OP_HI/LO, FUNCT_HI/LO, RN_HI/LO, RD_HI/LO).
  - Default RESET_PC.
- One combinational sub-module, instr_fields: slices instr into Cond/OpCode/Funct/Rn/Rd. The field layout then lives in one place, shared with any later pipeline stage.

Test Plan:
- Reset, then memory acks in the same cycle with 0xE2811001:
  - imem_addr=0x0 in cycle 1; instr_valid in cycle 2.
  - OpCode=2'b00, Funct=6'b101000, Rn=1, Rd=1.
  - After ready, next imem_addr=0x4.
- Memory acks 3 cycles after req, decode holds ready=0 for 4 cycles:
  - imem_addr is stable throughout FETCH.
  - instr, pc_out=0x4 and fields are unchanged during ISSUE.
  - A single pc increment on ready.
- Redirect to 0x100 while in FETCH with the ack 2 cycles later:
  - The stale data is never presented (instr_valid stays 0).
  - The next request is to 0x100.
- Redirect to 0x200 and instr_ready in the same ISSUE cycle: next imem_addr=0x200, not pc+4.
- RESET_PC=0xFFFF_FFFC, fetch and accept: next imem_addr=0x0000_0000 (wrap).
- With IF_BUSERR_EN, ack+err at 0x8:
  - fetch_fault=1 and stays set.
  - Later redirects are ignored.
  - rst_n low clears fetch_fault and restarts at RESET_PC.
